// File: rtl/aes_pkg.sv
`default_nettype none
// =====================================================================
// aes_pkg : shared encodings and state enum for the AES-128 sequencer
// Rev 1.0
// =====================================================================
package aes_pkg;

    localparam int AES_NR  = 10;
    localparam int AES_BLK = 128;

    localparam logic [1:0] OP_ARK = 2'd0;
    localparam logic [1:0] OP_SB  = 2'd1;
    localparam logic [1:0] OP_SR  = 2'd2;
    localparam logic [1:0] OP_MC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_step_decoder.sv
`default_nettype none
// =====================================================================
// aes_step_decoder : step index 0..4*NR-1 -> {op select, round, last}
// Rev 1.0
// =====================================================================
module aes_step_decoder
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
)
(
    input  logic [5:0] step,
    output logic [1:0] sel,
    output logic [3:0] round,
    output logic       last
);

    logic [5:0] w_rel;
    logic [3:0] w_rnd;

    // Steps after the initial ARK come in groups of four per round;
    // the final round reuses the MC slot for its ARK.
    assign w_rel = step - 6'd1;
    assign w_rnd = w_rel[5:2] + 4'd1;

    always_comb begin
        sel   = OP_ARK;
        round = 4'd0;
        if (step != 6'd0) begin
            round = w_rnd;
            case (w_rel[1:0])
                2'd0:    sel = OP_SB;
                2'd1:    sel = OP_SR;
                2'd2:    sel = (w_rnd == 4'(NR)) ? OP_ARK : OP_MC;
                default: sel = OP_ARK;
            endcase
        end
    end

    assign last = (step == 6'(4 * NR - 1));

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// =====================================================================
// aes_round_ctrl : AES-128 round sequencer driving the step modules
// Rev 1.0
// =====================================================================
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR             = AES_NR,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [AES_BLK-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [AES_BLK-1:0] out_data,
    output logic               op_start,
    output logic [1:0]         op_sel,
    output logic [3:0]         op_round,
    output logic [AES_BLK-1:0] op_state,
    input  logic               op_done,
    input  logic [AES_BLK-1:0] op_result,
    input  logic               abort,
    output logic               busy,
    output logic               err
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

    ctrl_state_e        r_state;
    ctrl_state_e        state_next;
    logic [AES_BLK-1:0] r_blk;
    logic [5:0]         r_step;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_err;

    logic               w_capture;
    logic               w_latch;
    logic               w_timeout;
    logic [1:0]         w_sel;
    logic [3:0]         w_round;
    logic               w_last;

    aes_step_decoder #(
        .NR (NR)
    ) u_dec (
        .step  (r_step),
        .sel   (w_sel),
        .round (w_round),
        .last  (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= state_next;
        end
    end

    // Abort overrides every other event, including a coincident op_done.
    always_comb begin
        state_next = r_state;
        w_capture  = 1'b0;
        w_latch    = 1'b0;
        w_timeout  = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w_capture  = 1'b1;
                        state_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: state_next = ST_WAIT;
                ST_WAIT: begin
                    if (op_done) begin
                        w_latch    = 1'b1;
                        state_next = w_last ? ST_OUT : ST_ISSUE;
                    end else if (TO_EN && (r_wait_cnt == CNT_LAST)) begin
                        w_timeout  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blk      <= '0;
            r_step     <= 6'd0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_timeout;

            if (w_capture) begin
                r_blk <= in_data;
            end else if (w_latch) begin
                r_blk <= op_result;
            end else if (w_timeout) begin
                r_blk <= '0;
            end

            if (w_capture || (state_next == ST_IDLE)) begin
                r_step <= 6'd0;
            end else if (w_latch && !w_last) begin
                r_step <= r_step + 6'd1;
            end

            // Cleared in ISSUE so the count reads zero on the first WAIT cycle.
            if (r_state == ST_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_OUT);
    assign busy      = (r_state != ST_IDLE);
    assign op_start  = (r_state == ST_ISSUE) && !abort;
    assign op_sel    = w_sel;
    assign op_round  = w_round;
    assign op_state  = r_blk;
    assign out_data  = r_blk;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// =====================================================================
// tb_aes_round_ctrl : directed/random bench with an AES reference model
// Rev 1.0
// =====================================================================
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         op_start;
    logic [1:0]   op_sel;
    logic [3:0]   op_round;
    logic [127:0] op_state;
    logic         op_done;
    logic [127:0] op_result;
    logic         abort;
    logic         busy;
    logic         err;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0]  sbox_t [256];
    logic [127:0] rk    [11];

    int q_sel[$];
    int q_rnd[$];
    int start_bad, time_bad, state_bad, t_hand;

    aes_round_ctrl #(
        .NR             (10),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .op_start  (op_start),
        .op_sel    (op_sel),
        .op_round  (op_round),
        .op_state  (op_state),
        .op_done   (op_done),
        .op_result (op_result),
        .abort     (abort),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- AES reference model ----------------
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] s, r;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        s = inv;
        r = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] gb(logic [127:0] s, int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_t[gb(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = gb(s, r + 4 * ((c + r) % 4));
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            o[127-8*(4*c+3) -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
        return o;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'd2);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_encrypt(logic [127:0] pt);
        logic [127:0] s = pt ^ rk[0];
        for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk[r];
        return shift_rows(sub_bytes(s)) ^ rk[10];
    endfunction

    // Stand-in for the real step modules behind the shared handshake.
    function automatic logic [127:0] aes_step(logic [1:0] sel, logic [3:0] rnd, logic [127:0] s);
        case (sel)
            2'd0:    return s ^ rk[rnd];
            2'd1:    return sub_bytes(s);
            2'd2:    return shift_rows(s);
            default: return mix_columns(s);
        endcase
    endfunction

    function automatic int sched_mismatch();
        int es[$];
        int er[$];
        int m = 0;
        es.push_back(0); er.push_back(0);
        for (int r = 1; r < 10; r++) begin
            es.push_back(1); er.push_back(r);
            es.push_back(2); er.push_back(r);
            es.push_back(3); er.push_back(r);
            es.push_back(0); er.push_back(r);
        end
        es.push_back(1); er.push_back(10);
        es.push_back(2); er.push_back(10);
        es.push_back(0); er.push_back(10);
        if (q_sel.size() != es.size()) m = m + 100;
        for (int i = 0; i < es.size() && i < q_sel.size(); i++)
            if (q_sel[i] != es[i] || q_rnd[i] != er[i]) m++;
        return m;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking and stimulus helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // mode 0: AES steps, mode 1: result = state + 1.
    // Returns early in WAIT of stall_step, or just after the abort edge.
    task automatic run_block(input logic [127:0] pt, input int mode, input int maxdly,
                             input int stall_step, input int abort_step,
                             output logic [127:0] ct, output int t_valid);
        logic [127:0] res;
        int d, n;
        q_sel.delete(); q_rnd.delete();
        start_bad = 0; time_bad = 0; state_bad = 0;
        ct = '0; t_valid = -1;
        in_data  = pt;
        in_valid = 1'b1;
        chk("in_ready_at_offer", in_ready, 1);
        t_hand = cyc;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            n = 0;
            while (!op_start && n < 20) begin tick(); n++; end
            if (!op_start) begin
                chk("op_start_seen", op_start, 1);
                return;
            end
            q_sel.push_back(int'(op_sel));
            q_rnd.push_back(int'(op_round));
            if (cyc != t_hand + 1 + 2 * k) time_bad++;
            if (mode == 1 && op_state !== pt + 128'(k)) state_bad++;
            res = (mode == 1) ? op_state + 128'd1 : aes_step(op_sel, op_round, op_state);
            tick();
            if (op_start) start_bad++;
            if (k == stall_step) return;
            d = (maxdly <= 1) ? 1 : int'($urandom_range(maxdly, 1));
            for (int j = 1; j < d; j++) tick();
            op_done   = 1'b1;
            op_result = res;
            abort     = (k == abort_step);
            tick();
            op_done   = 1'b0;
            abort     = 1'b0;
            op_result = rand128();
            if (k == abort_step) return;
        end
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk("out_valid_seen", out_valid, 1);
        t_valid = cyc;
        ct = out_data;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] pt, ct;
        int tv, w0, err_cnt, err_at, hold_bad;
        logic rdy_at_err, ov_at_err;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        op_done = 1'b0; op_result = '0; abort = 1'b0;
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        tick(); tick();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_start", op_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_op_sel", op_sel, 0);
        chk("rst_op_round", op_round, 0);
        chk("rst_op_state", op_state, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b1;
        tick();

        // FIPS-197 vector, 1-cycle done
        pt = 128'h00112233445566778899aabbccddeeff;
        run_block(pt, 0, 1, -1, -1, ct, tv);
        chk("fips_ct", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("fips_ct_model", ct, aes_encrypt(pt));
        chk("fips_latency", tv, t_hand + 81);
        chk("fips_issue_timing", time_bad, 0);
        chk("fips_sched", sched_mismatch(), 0);
        chk("fips_busy_out", busy, 1);
        handshake();
        chk("b2b_in_ready", in_ready, 1);
        chk("out_valid_dropped", out_valid, 0);

        // Schedule check with random done latency
        for (int b = 0; b < 3; b++) begin
            pt = rand128();
            run_block(pt, 1, 5, -1, -1, ct, tv);
            chk("rnd_sched", sched_mismatch(), 0);
            chk("rnd_start_width", start_bad, 0);
            chk("rnd_op_state", state_bad, 0);
            chk("rnd_out_data", ct, pt + 128'd40);
            handshake();
        end

        // Random plaintext through the AES steps with variable latency
        pt = rand128();
        run_block(pt, 0, 3, -1, -1, ct, tv);
        chk("aes_rand_ct", ct, aes_encrypt(pt));
        handshake();

        // Output backpressure
        pt = rand128();
        run_block(pt, 1, 1, -1, -1, ct, tv);
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || out_data !== pt + 128'd40 || in_ready !== 1'b0) hold_bad++;
            tick();
        end
        chk("bp_hold_stable", hold_bad, 0);
        chk("bp_out_data", out_data, pt + 128'd40);
        handshake();
        chk("bp_next_ready", in_ready, 1);

        // Abort colliding with op_done at step 12, offered right after the handshake
        pt = rand128();
        run_block(pt, 1, 1, -1, 12, ct, tv);
        chk("abort_idle", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_state_kept", op_state, pt + 128'd12);
        chk("abort_err", err, 0);
        tick();
        chk("abort_err_late", err, 0);
        pt = rand128();
        run_block(pt, 1, 4, -1, -1, ct, tv);
        chk("post_abort_ct", ct, pt + 128'd40);
        chk("post_abort_sched", sched_mismatch(), 0);
        handshake();

        // Timeout: step 5 never answered
        pt = rand128();
        run_block(pt, 1, 1, 5, -1, ct, tv);
        w0 = cyc; err_cnt = 0; err_at = -1; rdy_at_err = 1'b0; ov_at_err = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (err === 1'b1) begin
                err_cnt++;
                err_at     = cyc;
                rdy_at_err = in_ready;
                ov_at_err  = out_valid;
            end
            tick();
        end
        chk("to_err_count", err_cnt, 1);
        chk("to_err_cycle", err_at, w0 + 8);
        chk("to_in_ready", rdy_at_err, 1);
        chk("to_no_out_valid", ov_at_err, 0);
        chk("to_state_cleared", op_state, 0);

        // Asynchronous reset mid-WAIT
        pt = rand128();
        run_block(pt, 1, 2, 3, -1, ct, tv);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_op_state", op_state, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_op_round", op_round, 0);
        chk("arst_err", err, 0);
        tick(); tick();
        rst = 1'b1;
        op_done = 1'b1;
        op_result = rand128();
        tick(); tick();
        op_done = 1'b0;
        chk("spur_busy", busy, 0);
        chk("spur_op_state", op_state, 0);
        chk("spur_op_start", op_start, 0);
        chk("spur_err", err, 0);
        pt = rand128();
        run_block(pt, 1, 1, -1, -1, ct, tv);
        chk("final_ct", ct, pt + 128'd40);
        chk("final_latency", tv, t_hand + 81);
        handshake();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencer for the AES-128 encryption datapath. It accepts one plaintext block, then drives the per-step datapath modules (AddRoundKey, SubBytes, ShiftRows, MixColumns) through the standard 11-round schedule over a shared start/finish handshake. It holds the working state between steps and presents the ciphertext on a valid/ready output. It sits between the top-level engine interface and the step modules; key expansion is outside this block.

## Interface
- `NR`, 10: number of rounds; fixed to 10 for AES-128.
- `TIMEOUT_CYCLES`, 255: maximum cycles to wait for `op_done`; 0 disables the timeout.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all logic is posedge.
- `rst`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  a plaintext block is offered.
- `in_ready`  out  1  the block can accept a plaintext.
- `in_data`  in  128  plaintext block.
- `out_valid`  out  1  ciphertext is available.
- `out_ready`  in  1  downstream accepts the ciphertext.
- `out_data`  out  128  ciphertext block.
- `op_start`  out  1  one-cycle start pulse to the selected step module.
- `op_sel`  out  2  step select: 0 = ARK, 1 = SB, 2 = SR, 3 = MC.
- `op_round`  out  4  round number, 0..NR; drives the ARK roundnumber input.
- `op_state`  out  128  working state presented to the step modules.
- `op_done`  in  1  the selected step has finished.
- `op_result`  in  128  result of the step; valid together with `op_done`.
- `abort`  in  1  synchronous flush request.
- `busy`  out  1  a block is in flight.
- `err`  out  1  one-cycle pulse on timeout.

## Operation
- FSM states are IDLE, ISSUE, WAIT and OUT.
- **IDLE:** `in_ready`=1. When `in_valid`&`in_ready`, capture `in_data` into the state register, clear `step`/`round`, and go to ISSUE.
- **ISSUE:** assert `op_start` for exactly one cycle. `op_sel`/`op_round` come from the step decoder, and `op_state` is the state register. Go to WAIT.
- **WAIT:** the step has been issued and the block waits for `op_done`.
  - On `op_done`, latch `op_result` into the state register and advance the step.
  - If the finished step was the final one, go to OUT; otherwise go to ISSUE.
  - `op_done` is ignored in every state other than WAIT, and in the ISSUE cycle.
- **Step schedule (40 steps total):**
  - Round 0: ARK.
  - Rounds 1..NR-1: SB, SR, MC, ARK.
  - Round NR: SB, SR, ARK.
  - `op_round` increments after each ARK.
- **OUT:** `out_valid`=1 and `out_data` = the state register, both held stable until `out_ready`. On the handshake, go to IDLE.
- **Timeout:** a WAIT-cycle counter is cleared on entry to WAIT. If it reaches `TIMEOUT_CYCLES` (when nonzero) with no `op_done`, pulse `err`, discard the state and go to IDLE.
- **Abort:** `abort` in any state sends the FSM to IDLE on the next edge. `op_start` is not issued that cycle, `out_valid` drops, and `err` is not asserted. If `abort` and `op_done` arrive in the same cycle, abort wins.
- **busy:** `busy`=1 in ISSUE, WAIT and OUT.
- **Reset values:**
  - FSM = IDLE, so `in_ready`=1.
  - `out_valid`, `op_start`, `busy` and `err` = 0.
  - `op_sel`=0, `op_round`=0.
  - `op_state`, `out_data` and the state register = 0.
  - Asserting reset mid-operation drops everything immediately, with no `err`.

## Timing
- Input handshake at cycle T:
  - step k is issued at cycle T+1+2k;
  - with a datapath that returns `op_done` 1 cycle after `op_start`, `out_valid` rises at T+81.
- Every extra cycle of `op_done` latency adds 1 cycle per step.
- `op_done` must arrive at least 1 cycle after `op_start`.
- Back-to-back operation: after the output handshake, `in_ready`=1 on the next cycle. A new block costs at least 1 idle cycle between blocks.
- All outputs are registered or decoded only from the FSM state; no combinational path exists from `in_valid`/`op_done` to `op_start`.

## Structure
- **Shared package `aes_pkg`:**
  - op encodings `OP_ARK`/`OP_SB`/`OP_SR`/`OP_MC`;
  - `AES_NR`=10, `AES_BLK`=128;
  - the FSM state enum.
- **Sub-module `aes_step_decoder`:** combinational; maps the step index 0..39 to {`op_sel`, `op_round`, `last`}.
- The FSM, the state register and the timeout counter stay in `aes_round_ctrl`.

## Test plan
- **Standard vector:** FIPS-197 vector, plaintext 00112233445566778899aabbccddeeff with key 000102…0f, using the real step modules behind a 1-cycle done. Require `out_data` = 69c4e0d86a7b0430d8cdb78070b4c55a at T+81.
- **Schedule check:** stub returns `op_result`=`op_state`+1 with a random 1..5 cycle done delay. Check the exact 40-entry `op_sel`/`op_round` sequence, `out_data` = `in_data`+40, and `op_start` is always 1 cycle wide.
- **Output backpressure:** hold `out_ready`=0 for 20 cycles. `out_valid`/`out_data` stay stable, `in_ready`=0 throughout, and the block accepts the next input the cycle after the handshake.
- **Timeout:** `TIMEOUT_CYCLES`=8 and the stub never answers step 5. Require `err` to pulse once exactly 8 cycles into WAIT, then IDLE with `in_ready`=1 and no `out_valid`.
- **Abort collision:** assert `abort` in the same cycle as `op_done` at step 12. Require IDLE next cycle, the state not updated, and no `err`. A following block completes correctly.
- **Reset mid-operation:** drive `rst` low asynchronously mid-WAIT. All outputs reach their reset values without waiting for `clk`. Spurious `op_done` after release is ignored.
